// File: rtl/prio_encoder_q.sv
// Registered N-bit priority encoder with fixed-priority or round-robin arbitration.
// Each encoded result is queued in a DEPTH-entry FIFO behind EN/RDY handshakes.
module prio_encoder_q #(
    parameter int N     = 8,
    parameter int W     = 3,
    parameter int DEPTH = 2
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [N-1:0] enc_req,
    input  logic         mode,
    input  logic         EN_enc,
    output logic         RDY_enc,
    output logic [W-1:0] out_value,
    output logic [N-1:0] out_onehot,
    output logic         out_multi,
    output logic         RDY_out,
    input  logic         EN_out,
    output logic         err_ovf,
    output logic         err_zero
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [W-1:0] idx;
        logic         multi;
    } entry_t;

    logic [CW-1:0] count;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [W-1:0]  ptr;
    entry_t        mem [DEPTH];
    entry_t        head_entry;

    logic [N-1:0]  rot_req;
    logic [W-1:0]  winner;
    logic          multi;
    logic          req_any;
    logic          push;
    logic          pop;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Bit k of rot_req is request line (ptr + k) mod N, so the lowest set bit is the RR winner.
    assign rot_req = N'({enc_req, enc_req} >> ptr);
    assign req_any = |enc_req;
    assign multi   = (enc_req & (enc_req - N'(1))) != '0;

    // NOTE: winner gets a default before the loops so no path leaves it unassigned (no latch).
    always_comb begin
        int pos;
        winner = '0;
        pos    = 0;
        if (!mode) begin
            for (int i = 0; i < N; i++) begin
                if (enc_req[i]) winner = W'(i);
            end
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                pos = int'(ptr) + k;
                if (pos >= N) pos = pos - N;
                if (rot_req[k]) winner = W'(pos);
            end
        end
    end

    assign RDY_enc = (count < CW'(DEPTH));
    assign RDY_out = (count != '0);
    assign push    = EN_enc && RDY_enc && req_any;
    assign pop     = EN_out && RDY_out;

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count    <= '0;
            head     <= '0;
            tail     <= '0;
            ptr      <= '0;
            err_ovf  <= 1'b0;
            err_zero <= 1'b0;
        end else begin
            if (push) tail <= wrap_inc(tail);
            if (pop)  head <= wrap_inc(head);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push && mode) ptr <= (winner == W'(N - 1)) ? '0 : winner + W'(1);
            if (EN_enc && !RDY_enc) err_ovf <= 1'b1;
            if (EN_enc && RDY_enc && !req_any) err_zero <= 1'b1;
        end
    end

    // NOTE: storage is not reset; count alone decides which entries are valid.
    always_ff @(posedge CLK) begin
        if (push) mem[tail] <= '{idx: winner, multi: multi};
    end

    assign head_entry = mem[head];
    assign out_value  = RDY_out ? head_entry.idx : '0;
    assign out_multi  = RDY_out ? head_entry.multi : 1'b0;
    assign out_onehot = RDY_out ? (N'(1) << head_entry.idx) : '0;

endmodule
